// File: rtl/counter_seq_pkg.sv
// Shared types for the counter command sequencer: command opcodes,
// sequencer FSM states and the number of requesters sharing the counter.
package counter_seq_pkg;

  localparam int N_REQ = 2;

  typedef enum logic [1:0] {
    OP_CLEAR = 2'd0,
    OP_LOAD  = 2'd1,
    OP_UP    = 2'd2,
    OP_DOWN  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter. The grant is combinational from the request
// vector; the priority pointer only moves when the grant is actually taken,
// so a requester that is offered but not accepted keeps its turn.
module rr_arb2
  import counter_seq_pkg::*;
(
  input  logic             clk,
  input  logic             clear,
  input  logic [N_REQ-1:0] req,
  input  logic             accept,
  output logic [N_REQ-1:0] gnt
);

  // Requester that wins a tie; after reset requester 0 goes first.
  logic prio;

  // Single request wins outright; a tie goes to the favoured requester.
  always_comb begin
    gnt = req;
    if (&req) begin
      gnt = prio ? 2'b10 : 2'b01;
    end
  end

  // Favour the requester that was not served by the accepted grant.
  always_ff @(posedge clk) begin
    if (clear) begin
      prio <= 1'b0;
    end else if (accept) begin
      prio <= ~gnt[1];
    end
  end

endmodule

// File: rtl/counter_seq_arbiter.sv
// Command sequencer that shares one counter between two requesters.
// Each accepted command (clear, load, count up/down by N) drives the counter
// control pins for exactly the cycles it needs, waits one settle cycle, then
// returns the counter value on a response channel tagged with the requester.
// Optional feature: define COUNTER_SEQ_SAT_EN to clamp step counts so the
// counter never wraps, flagging truncation on rsp_err.
module counter_seq_arbiter
  import counter_seq_pkg::*;
#(
  parameter  int WIDTH  = 8,
  parameter  int STEP_W = 8,
  localparam int ARG_W  = (WIDTH > STEP_W) ? WIDTH : STEP_W
) (
  input  logic                   clk,
  input  logic                   clear,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [2*N_REQ-1:0]     req_op,
  input  logic [N_REQ*ARG_W-1:0] req_arg,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   rsp_err,
  output logic                   cnt_clear,
  output logic                   cnt_load,
  output logic [WIDTH-1:0]       cnt_d,
  output logic                   cnt_up_down,
  output logic                   cnt_en,
  input  logic [WIDTH-1:0]       cnt_q
);

  state_e            state;
  logic [STEP_W-1:0] step_rem;
  logic [N_REQ-1:0]  gnt;
  logic              accept;
  logic              gnt_id;
  op_e               sel_op;
  logic [ARG_W-1:0]  sel_arg;
  logic [STEP_W-1:0] sel_steps;
  logic [STEP_W-1:0] eff_steps;
  logic              sel_trunc;

`ifdef COUNTER_SEQ_SAT_EN
  // Limit a step count to the distance between the current value and the
  // bound in the counting direction; MSB of the result flags truncation.
  function automatic logic [STEP_W:0] sat_steps(input op_e              op,
                                                input logic [STEP_W-1:0] steps,
                                                input logic [WIDTH-1:0]  q);
    logic [ARG_W-1:0] want;
    logic [ARG_W-1:0] room;
    want = ARG_W'(steps);
    room = (op == OP_UP) ? ARG_W'(~q) : ARG_W'(q);
    if (want > room) begin
      return {1'b1, STEP_W'(room)};
    end
    return {1'b0, steps};
  endfunction
`endif

  rr_arb2 u_arb (
    .clk    (clk),
    .clear  (clear),
    .req    (req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  // Grants are only offered while idle, and never during reset.
  assign accept    = (state == IDLE) && (|gnt) && !clear;
  assign req_ready = accept ? gnt : '0;
  assign gnt_id    = gnt[1];

  // Select the granted requester's command and work out its effective length.
  always_comb begin
    sel_op    = op_e'(gnt_id ? req_op[3:2] : req_op[1:0]);
    sel_arg   = gnt_id ? req_arg[2*ARG_W-1:ARG_W] : req_arg[ARG_W-1:0];
    sel_steps = sel_arg[STEP_W-1:0];
`ifdef COUNTER_SEQ_SAT_EN
    {sel_trunc, eff_steps} = sat_steps(sel_op, sel_steps, cnt_q);
`else
    eff_steps = sel_steps;
    sel_trunc = 1'b0;
`endif
  end

  // Sequencer FSM: counter control pins and response are registered here.
  always_ff @(posedge clk) begin
    if (clear) begin
      state       <= IDLE;
      step_rem    <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      cnt_clear   <= 1'b0;
      cnt_load    <= 1'b0;
      cnt_d       <= '0;
      cnt_up_down <= 1'b0;
      cnt_en      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_id  <= gnt_id;
            rsp_err <= 1'b0;
            case (sel_op)
              OP_CLEAR: begin
                cnt_clear <= 1'b1;
                step_rem  <= STEP_W'(1);
                state     <= EXEC;
              end
              OP_LOAD: begin
                cnt_load <= 1'b1;
                cnt_d    <= sel_arg[WIDTH-1:0];
                step_rem <= STEP_W'(1);
                state    <= EXEC;
              end
              default: begin
                rsp_err <= sel_trunc;
                // A zero-length step leaves every control low and goes
                // straight to the settle cycle.
                if (eff_steps == '0) begin
                  state <= SETTLE;
                end else begin
                  cnt_en      <= 1'b1;
                  cnt_up_down <= (sel_op == OP_UP);
                  step_rem    <= eff_steps;
                  state       <= EXEC;
                end
              end
            endcase
          end
        end
        EXEC: begin
          step_rem <= step_rem - STEP_W'(1);
          if (step_rem == STEP_W'(1)) begin
            cnt_clear   <= 1'b0;
            cnt_load    <= 1'b0;
            cnt_up_down <= 1'b0;
            cnt_en      <= 1'b0;
            state       <= SETTLE;
          end
        end
        SETTLE: begin
          rsp_data  <= cnt_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_counter_seq_arbiter.sv
// Bench for counter_seq_arbiter: a behavioural counter sits on the cnt_* pins,
// a monitor predicts each response from the command rules at acceptance and
// checks it when the response appears.
module tb_counter_seq_arbiter;

  logic        clk = 1'b0;
  logic        clear;
  logic [1:0]  req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_arg;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [7:0]  rsp_data, cnt_d, cnt_q;
  logic        cnt_clear, cnt_load, cnt_up_down, cnt_en;

  logic        v0, v1;
  logic [1:0]  op0, op1;
  logic [7:0]  a0, a1;
  assign req_valid = {v1, v0};
  assign req_op    = {op1, op0};
  assign req_arg   = {a1, a0};

  always #5 clk = ~clk;

  counter_seq_arbiter #(.WIDTH(8), .STEP_W(8)) dut (
    .clk(clk), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_arg(req_arg),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cnt_clear(cnt_clear), .cnt_load(cnt_load), .cnt_d(cnt_d),
    .cnt_up_down(cnt_up_down), .cnt_en(cnt_en), .cnt_q(cnt_q)
  );

  // Behavioural stand-in for the shared counter.
  logic [7:0] cq = 8'h00;
  always @(posedge clk) begin
    if (cnt_clear)   cq <= 8'h00;
    else if (cnt_load) cq <= cnt_d;
    else if (cnt_en) cq <= cnt_up_down ? cq + 8'd1 : cq - 8'd1;
  end
  assign cnt_q = cq;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endfunction

  typedef struct {
    int id;
    int data;
    int err;
    int due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   in_rsp = 0;
  int   mval = 0;
  int   last_gnt = 1;
  int   hs_cyc = -1;
  int   last_acc_cyc = -1;
  int   gseq[$];
  logic [7:0] held_data;
  logic held_id, held_err;

  // Monitor: predict at acceptance, compare when the response shows up.
  always @(negedge clk) begin : mon
    int gid, o, a, n, nv, err;
    if (clear) begin
      exp_q.delete();
      in_rsp   = 0;
      last_gnt = 1;
    end else begin
      if (rsp_valid) begin
        if (!in_rsp) begin
          chk("rsp_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            chk("rsp_id", rsp_id, cur.id);
            chk("rsp_data", rsp_data, cur.data);
            chk("rsp_err", rsp_err, cur.err);
            chk("rsp_latency", cyc, cur.due);
          end
          in_rsp    = 1;
          held_id   = rsp_id;
          held_err  = rsp_err;
          held_data = rsp_data;
        end else begin
          chk("rsp_stable", {rsp_id, rsp_err, rsp_data}, {held_id, held_err, held_data});
        end
        if (rsp_ready) begin
          in_rsp = 0;
          hs_cyc = cyc;
        end
      end
      if (req_ready != 2'b00) begin
        gid = req_ready[1] ? 1 : 0;
        chk("gnt_onehot", $onehot(req_ready), 1);
        chk("gnt_valid", req_ready & ~req_valid, 0);
        chk("gnt_no_rsp", rsp_valid, 0);
        if (req_valid == 2'b11) chk("arb_rr", gid, 1 - last_gnt);
        o = gid ? int'(req_op[3:2]) : int'(req_op[1:0]);
        a = gid ? int'(req_arg[15:8]) : int'(req_arg[7:0]);
        n = 1;
        err = 0;
        nv = 0;
        case (o)
          0: nv = 0;
          1: nv = a;
          2: begin
            n = a;
`ifdef COUNTER_SEQ_SAT_EN
            if (mval + n > 255) begin n = 255 - mval; err = 1; end
`endif
            nv = (mval + n) % 256;
          end
          default: begin
            n = a;
`ifdef COUNTER_SEQ_SAT_EN
            if (n > mval) begin n = mval; err = 1; end
`endif
            nv = (mval - n + 256) % 256;
          end
        endcase
        exp_q.push_back('{id: gid, data: nv, err: err, due: cyc + n + 2});
        mval         = nv;
        last_gnt     = gid;
        last_acc_cyc = cyc;
        gseq.push_back(gid);
      end
    end
  end

  task automatic issue(input int id, input int op, input int arg, input int patience, input bit must);
    bit got;
    @(posedge clk); #1;
    if (id == 0) begin v0 = 1'b1; op0 = op[1:0]; a0 = arg[7:0]; end
    else begin v1 = 1'b1; op1 = op[1:0]; a1 = arg[7:0]; end
    got = 0;
    for (int t = 0; t < patience && !got; t++) begin
      @(negedge clk);
      if (req_ready[id]) got = 1;
      @(posedge clk); #1;
    end
    if (id == 0) v0 = 1'b0; else v1 = 1'b0;
    if (must) chk("grant_in_time", got, 1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || in_rsp || rsp_valid) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", t < 3000, 1);
  endtask

  task automatic rand_req(input int id, input int count);
    for (int k = 0; k < count; k++) begin
      int op, arg, pat;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      op = $urandom_range(0, 3);
      if (op >= 2) arg = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 12);
      else arg = $urandom_range(0, 255);
      pat = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 400;
      issue(id, op, arg, pat, pat == 400);
    end
  endtask

  bit done0 = 0;
  bit done1 = 0;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    clear = 1'b1; v0 = 0; v1 = 0; op0 = 0; op1 = 0; a0 = 0; a1 = 0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 clear = 1'b0;
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    chk("rst_cnt", {cnt_clear, cnt_load, cnt_up_down, cnt_en, cnt_d}, 0);

    // LOAD then CLEAR from requester 0
    issue(0, 1, 8'h5A, 50, 1); drain();
    issue(0, 0, 0, 50, 1);     drain();

    // zero-length and multi-step counts
    issue(0, 1, 8'h10, 50, 1); drain();
    issue(0, 2, 0, 50, 1);     drain();
    issue(0, 1, 8'h10, 50, 1); drain();
    issue(0, 3, 3, 50, 1);     drain();

    // wrap / saturation at the top
    issue(0, 1, 8'hFE, 50, 1); drain();
    issue(0, 2, 5, 50, 1);     drain();

    // contention twice in a row, after requester 1 was served last
    issue(1, 0, 0, 50, 1); drain();
    fork
      issue(0, 2, 3, 100, 1);
      issue(1, 2, 4, 100, 1);
    join
    fork
      issue(0, 3, 1, 100, 1);
      issue(1, 1, 8'h77, 100, 1);
    join
    drain();
    chk("contention_order",
        gseq[gseq.size()-4] * 8 + gseq[gseq.size()-3] * 4 + gseq[gseq.size()-2] * 2 + gseq[gseq.size()-1],
        5);

    // response backpressure with requester 1 waiting
    rsp_ready = 1'b0;
    issue(0, 1, 8'h33, 50, 1);
    fork
      issue(1, 1, 8'h44, 100, 1);
      begin
        int t;
        t = 0;
        while (!rsp_valid && t < 20) begin @(negedge clk); t++; end
        chk("bp_rsp_seen", rsp_valid, 1);
        repeat (6) @(negedge clk);
        @(posedge clk); #1 rsp_ready = 1'b1;
      end
    join
    chk("bp_grant_gap", last_acc_cyc, hs_cyc + 1);
    drain();

    // reset in the middle of a 10-step count
    issue(0, 1, 8'h20, 50, 1); drain();
    issue(0, 2, 10, 50, 1);
    repeat (3) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    chk("midrst_ready", req_ready, 0);
    chk("midrst_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data}, 0);
    chk("midrst_cnt", {cnt_clear, cnt_load, cnt_up_down, cnt_en, cnt_d}, 0);
    mval = 8'h24;
    repeat (4) @(negedge clk);
    chk("midrst_counter_stopped", cq, 8'h24);
    chk("midrst_no_rsp", rsp_valid, 0);
    issue(1, 2, 1, 50, 1); drain();

    // randomized traffic from both requesters with random backpressure
    fork
      begin rand_req(0, 25); done0 = 1; end
      begin rand_req(1, 25); done1 = 1; end
      begin
        while (!(done0 && done1)) begin
          @(posedge clk); #1 rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    rsp_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_seq_arbiter.md
# counter_seq_arbiter

- Shares one `behav_counter` instance between two requesters.
- Accepts clear, load, count-up and count-down commands on two valid/ready ports and arbitrates them round-robin.
- Sequences the counter's control pins for the exact number of cycles each command needs.
- Returns the settled counter value on a per-requester-tagged response channel.
- Sits directly in front of the counter; the counter is only ever driven by this block.

## Interface

Parameters:
- `WIDTH`, 8: counter and data width.
- `STEP_W`, 8: width of the step-count argument.

Ports:
- `clk` in 1: single clock, rising edge.
- `clear` in 1: reset, synchronous, active-high.
- `req_valid` in 2: command valid, one bit per requester.
- `req_ready` out 2: command accepted, one-hot or zero.
- `req_op` in 2x2: per requester. 0 = CLEAR, 1 = LOAD, 2 = UP, 3 = DOWN.
- `req_arg` in 2xmax(WIDTH,STEP_W): LOAD value, or step count for UP/DOWN.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: response accepted.
- `rsp_id` out 1: requester the response belongs to.
- `rsp_data` out WIDTH: counter value after the command.
- `rsp_err` out 1: step command was truncated (only with `COUNTER_SEQ_SAT_EN`).
- `cnt_clear` out 1: drives counter `clear`.
- `cnt_load` out 1: drives counter `load`.
- `cnt_d` out WIDTH: drives counter `d`.
- `cnt_up_down` out 1: counter direction, 1 = up.
- `cnt_en` out 1: counter count enable.
- `cnt_q` in WIDTH: counter `qd`.

## Operation

FSM states: IDLE, EXEC, SETTLE, RESP.

- **IDLE**
  - If any `req_valid` is high, grant one requester: assert its `req_ready` for one cycle and latch op, arg and id.
  - Go to EXEC.
- **EXEC**
  - CLEAR: `cnt_clear`=1 for 1 cycle.
  - LOAD: `cnt_load`=1 and `cnt_d`=arg for 1 cycle.
  - UP/DOWN: `cnt_en`=1 and `cnt_up_down` set per op for N cycles, where N = effective step count. N=0 skips EXEC and goes straight to SETTLE.
  - A step down-counter tracks the remaining cycles.
- **SETTLE**
  - One cycle with all `cnt_*` controls low, so `cnt_q` reflects the command.
  - At the end of SETTLE, register `rsp_data` ← `cnt_q`. Go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_id`, `rsp_data` and `rsp_err` held stable.
  - Leave on `rsp_valid & rsp_ready` and return to IDLE.
  - No new grant is made while in RESP.

Arbitration:
- Round-robin with a last-grant pointer.
- When both requesters are valid, grant the one not granted last.
- After reset the pointer favours requester 0.
- A requester whose valid drops before grant is simply not served.

Arithmetic:
- Without saturation, counting wraps modulo 2^WIDTH: 0xFF + 1 = 0x00 at WIDTH=8.
- `cnt_d` is `req_arg[WIDTH-1:0]`.

Reset:
- Applies on any cycle, including mid-EXEC.
- State → IDLE, pointer → requester 0, pending command discarded, no response issued.
- All outputs 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_data`, `rsp_err`, `cnt_*`.

## Timing

- Acceptance at cycle 0 (`req_ready` high).
- EXEC occupies cycles 1..N (N=1 for CLEAR/LOAD).
- SETTLE occupies cycle N+1.
- `rsp_valid` first high at cycle N+2.
- Back-to-back throughput: the next grant comes at the earliest one cycle after the response handshake.
- `req_ready` is never asserted in the same cycle as `rsp_valid`.

## Configuration

Macro: `COUNTER_SEQ_SAT_EN`.

- **Defined:**
  - Clamp the step count at acceptance to the distance to the bound: UP uses (2^WIDTH−1−`cnt_q`), DOWN uses `cnt_q`.
  - If clamping occurred, `rsp_err`=1.
  - The counter never wraps.
- **Undefined:**
  - Steps are used unmodified and wrap-around is allowed.
  - `rsp_err` is tied 0.

## Structure

- Package `counter_seq_pkg` holds:
  - op enum (`OP_CLEAR`, `OP_LOAD`, `OP_UP`, `OP_DOWN`);
  - FSM state enum;
  - requester count constant (2).
- Sub-module `rr_arb2`: two-input round-robin arbiter with grant-accept pointer update.
- FSM, step counter and response registers live in the top module.

## Test plan

- **Reset:** assert `clear` during UP of 10 steps at step 4 → all outputs 0 next cycle; counter stops; no `rsp_valid`.
- **LOAD and CLEAR:** req0 LOAD 0x5A → `rsp_valid` 3 cycles after accept, `rsp_data`=0x5A, `rsp_id`=0. Then CLEAR → `rsp_data`=0x00.
- **Contention:** both valid simultaneously, twice in a row → grants alternate 0, 1, 0, 1. Responses are tagged accordingly, with no overlap.
- **Step counts:** UP arg 0 from 0x10 → `rsp_data`=0x10, `rsp_valid` 2 cycles after accept. DOWN arg 3 from 0x10 → 0x0D, response at cycle 5.
- **Wrap/saturation:** LOAD 0xFE then UP 5.
  - Without macro: `rsp_data`=0x03, `rsp_err`=0.
  - With `COUNTER_SEQ_SAT_EN`: `rsp_data`=0xFF, `rsp_err`=1.
- **Response backpressure:** hold `rsp_ready`=0 for 6 cycles → `rsp_*` stable; no `req_ready` while req1 is waiting; req1 is granted 1 cycle after the handshake.
